// File: rtl/nemo_spi_slave_if.sv
// nemo_spi_slave_if -- SPI bus between the inertial interface (master) and
// the sensor model (slave).
//   SS_n  slave select, active low      SCLK  SPI clock, mode 3 (idles high)
//   MOSI  data master -> slave          MISO  data slave -> master
//   INT   data-ready interrupt, active high, slave -> master
interface nemo_spi_slave_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic INT;

  modport master (output SS_n, output SCLK, output MOSI, input MISO, input INT);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO, output INT);
endinterface

// File: rtl/nemo_spi_slave.sv
// nemo_spi_slave -- SPI responder modelling the inertial sensor end of the bus.
// 16-bit frames, MSB first: bit15 R/W (1=read), bits14:8 address, bits7:0 data.
//   0x00-0x1F  R/W config bytes
//   0x20-0x27  read-only sample bytes (ch n low at 0x20+2n, high at 0x21+2n)
//   others     writes dropped, reads return 0x00
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   spi          slave modport of nemo_spi_slave_if (SS_n/SCLK/MOSI in, MISO/INT out)
//   smpl_vld     one-clk strobe qualifying smpl_data
//   smpl_data    four 16-bit channels, ch0 in [15:0] .. ch3 in [63:48]
//   setup_done   sticky, set once INT_CFG_ADDR, 0x10 and 0x11 have been written
// Optional build macro: NEMO_BURST_EN -- after the 16th bit, every further
// 8 bits access the next address (wrapping 0x7F->0x00).
module nemo_spi_slave #(
  parameter int         SCLK_SYNC_STAGES = 2,
  parameter logic [6:0] INT_CFG_ADDR     = 7'h0D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nemo_spi_slave_if.slave      spi,
  input  logic                 smpl_vld,
  input  logic [63:0]          smpl_data,
  output logic                 setup_done
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  localparam int N = (SCLK_SYNC_STAGES < 2) ? 2 : SCLK_SYNC_STAGES;

  // synchronizers; SS_n/SCLK reset to their idle-high level so no false
  // edge is seen when reset releases
  logic [N-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic         ss_prev_q, sclk_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
    end else begin
      ss_sync_q   <= {ss_sync_q[N-2:0], spi.SS_n};
      sclk_sync_q <= {sclk_sync_q[N-2:0], spi.SCLK};
      mosi_sync_q <= {mosi_sync_q[N-2:0], spi.MOSI};
      ss_prev_q   <= ss_sync_q[N-1];
      sclk_prev_q <= sclk_sync_q[N-1];
    end
  end

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  assign ss_s      = ss_sync_q[N-1];
  assign sclk_s    = sclk_sync_q[N-1];
  assign mosi_s    = mosi_sync_q[N-1];
  assign ss_fall   =  ss_prev_q   & ~ss_s;
  assign ss_rise   = ~ss_prev_q   &  ss_s;
  assign sclk_rise = ~sclk_prev_q &  sclk_s;
  assign sclk_fall =  sclk_prev_q & ~sclk_s;

  // state
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      tx_q, tx_d;
  logic            miso_q, miso_d;
  logic            rw_q, rw_d;
  logic [6:0]      addr_q, addr_d;
  logic [31:0][7:0] cfg_q, cfg_d;
  logic [7:0][7:0] data_q, data_d;
  logic            pend_q, pend_d;
  logic [63:0]     pend_data_q, pend_data_d;
  logic            int_q, int_d;
  logic            rd27_q, rd27_d;
  logic [2:0]      flags_q, flags_d;
  logic            setup_q, setup_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      cfg_q       <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      int_q       <= 1'b0;
      rd27_q      <= 1'b0;
      flags_q     <= '0;
      setup_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      cfg_q       <= cfg_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      int_q       <= int_d;
      rd27_q      <= rd27_d;
      flags_q     <= flags_d;
      setup_q     <= setup_d;
    end
  end

  // byte being completed by the current SCLK rise
  logic [7:0] shift_byte;
  assign shift_byte = {rx_q[6:0], mosi_s};

  // read lookup: the address about to be accessed (command decode or the
  // next burst address)
  logic [6:0] nxt_addr;
  logic [7:0] rd_byte;
  assign nxt_addr = (state_q == CMD) ? shift_byte[6:0] : addr_q + 7'd1;

  always_comb begin
    rd_byte = '0;
    if (nxt_addr[6:5] == 2'b00)        rd_byte = cfg_q[nxt_addr[4:0]];
    else if (nxt_addr[6:3] == 4'b0100) rd_byte = data_q[nxt_addr[2:0]];
  end

  logic wr_en, load_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    cfg_d       = cfg_q;
    data_d      = data_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    int_d       = int_q;
    rd27_d      = rd27_q;
    flags_d     = flags_q;
    setup_d     = setup_q;
    wr_en       = 1'b0;
    load_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          miso_d  = 1'b0;
          rd27_d  = 1'b0;
        end
      end
      CMD: begin
        if (sclk_rise && cnt_q < 4'd8) begin
          rx_d  = shift_byte;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            rw_d   = rx_q[6];
            addr_d = shift_byte[6:0];
            tx_d   = rd_byte;
          end
        end
        // MISO stays 0 in CMD; the first fall after the command byte
        // presents read-data bit7 and moves to DATA
        if (sclk_fall && cnt_q == 4'd8) begin
          state_d = DATA;
          miso_d  = tx_q[7];
          tx_d    = {tx_q[6:0], 1'b0};
        end
      end
      DATA: begin
        if (sclk_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
        if (sclk_rise) begin
          rx_d  = shift_byte;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            if (!rw_q)                   wr_en  = 1'b1;
            else if (addr_q == 7'h27)    rd27_d = 1'b1;
`ifdef NEMO_BURST_EN
            addr_d = nxt_addr;
            tx_d   = rd_byte;
            cnt_d  = 4'd8;
`else
            state_d = DONE;
            miso_d  = 1'b0;
`endif
          end
        end
      end
      default: ;  // DONE: SCLK ignored until SS_n rises
    endcase

    if (ss_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end

    // config write commit
    if (wr_en && addr_q[6:5] == 2'b00) begin
      cfg_d[addr_q[4:0]] = shift_byte;
      if (addr_q == INT_CFG_ADDR) flags_d[0] = 1'b1;
      if (addr_q == 7'h10)        flags_d[1] = 1'b1;
      if (addr_q == 7'h11)        flags_d[2] = 1'b1;
    end
    setup_d = setup_q | (&flags_d);

    // samples load immediately while the bus is idle; during a frame they
    // wait in the pending buffer so a read never sees a torn sample set
    if (smpl_vld && ss_s) begin
      load_en = 1'b1;
      data_d  = smpl_data;
    end else if (ss_rise && pend_q) begin
      load_en = 1'b1;
      data_d  = pend_data_q;
    end
    if (ss_rise) pend_d = 1'b0;
    if (smpl_vld && !ss_s) begin
      pend_d      = 1'b1;
      pend_data_d = smpl_data;
    end

    // INT: set has priority over both clear sources
    if (ss_rise && rd27_q) int_d = 1'b0;
    if (wr_en && addr_q == INT_CFG_ADDR && !shift_byte[1]) int_d = 1'b0;
    if (load_en && cfg_q[INT_CFG_ADDR[4:0]][1]) int_d = 1'b1;
  end

  assign spi.MISO   = miso_q;
  assign spi.INT    = int_q;
  assign setup_done = setup_q;

endmodule

// File: tb/tb_nemo_spi_slave.sv
// tb_nemo_spi_slave -- directed bench for nemo_spi_slave. Stimulus pushes the
// expected value into a scoreboard queue; a monitor pops and compares each
// time the bench presents an observed DUT value.
module tb_nemo_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        smpl_vld;
  logic [63:0] smpl_data;
  logic        setup_done;

  nemo_spi_slave_if bus();

  nemo_spi_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (bus),
    .smpl_vld   (smpl_vld),
    .smpl_data  (smpl_data),
    .setup_done (setup_done)
  );

  always #5 clk = ~clk;

  localparam int HALF = 8;  // SCLK half period in clk

  typedef struct {
    string       nm;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [15:0] obs;
  logic        obs_stb = 1'b0;
  logic        end_stb = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  // monitor
  always @(posedge clk) begin
    if (obs_stb) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard-empty: observed %h with nothing expected", obs);
      end else begin
        cur = sb.pop_front();
        if (obs !== cur.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", cur.nm, obs, cur.exp);
        end
      end
    end
    if (end_stb && sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard-leftover: %0d expectations never observed", sb.size());
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_v(input string nm, input logic [15:0] v);
    sb.push_back('{nm, v});
  endtask

  task automatic observe(input logic [15:0] v);
    obs     = v;
    obs_stb = 1'b1;
    @(negedge clk);
    obs_stb = 1'b0;
  endtask

  // one SPI frame, tx MSB-aligned in [39:0]; received bits end up in rx[nbits-1:0]
  task automatic spi_xfer(input logic [39:0] tx, input int nbits, input bit do_pulse,
                          input logic [63:0] pdata, output logic [39:0] rx);
    rx = '0;
    bus.SS_n = 1'b0;
    wclk(HALF);
    for (int i = 0; i < nbits; i++) begin
      bus.SCLK = 1'b0;
      bus.MOSI = tx[39-i];
      wclk(HALF);
      rx = {rx[38:0], bus.MISO};
      bus.SCLK = 1'b1;
      wclk(HALF);
      if (do_pulse && i == 4) begin
        smpl_vld  = 1'b1;
        smpl_data = pdata;
        wclk(1);
        smpl_vld  = 1'b0;
      end
    end
    bus.SS_n = 1'b1;
    wclk(HALF);
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] e, input string nm);
    logic [39:0] rx;
    expect_v(nm, {8'h00, e});
    spi_xfer({1'b1, a, 8'h00, 24'h0}, 16, 1'b0, 64'h0, rx);
    observe({8'h00, rx[7:0]});
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    logic [39:0] rx;
    spi_xfer({1'b0, a, d, 24'h0}, 16, 1'b0, 64'h0, rx);
  endtask

  task automatic load_smpl(input logic [63:0] d);
    smpl_vld  = 1'b1;
    smpl_data = d;
    wclk(1);
    smpl_vld  = 1'b0;
    wclk(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] rx;
    rst_n     = 1'b0;
    bus.SS_n  = 1'b1;
    bus.SCLK  = 1'b1;
    bus.MOSI  = 1'b0;
    smpl_vld  = 1'b0;
    smpl_data = '0;
    wclk(5);
    rst_n = 1'b1;
    wclk(3);

    // reset state
    expect_v("reset-MISO", 16'h0); observe({15'h0, bus.MISO});
    expect_v("reset-INT", 16'h0);  observe({15'h0, bus.INT});
    expect_v("reset-setup", 16'h0); observe({15'h0, setup_done});
    rd(7'h10, 8'h00, "rd10-reset");

    // setup writes
    wr(7'h0D, 8'h02);
    wr(7'h10, 8'h62);
    expect_v("setup-after-2", 16'h0); observe({15'h0, setup_done});
    wr(7'h11, 8'h0C);
    expect_v("setup-after-3", 16'h1); observe({15'h0, setup_done});
    rd(7'h10, 8'h62, "rd10");
    rd(7'h11, 8'h0C, "rd11");

    // INT on sample load, cleared by read of 0x27
    load_smpl(64'h1100_BEEF_0000_FF00);
    expect_v("int-set", 16'h1); observe({15'h0, bus.INT});
    rd(7'h20, 8'h00, "rd20");
    rd(7'h21, 8'hFF, "rd21");
    expect_v("int-still-set", 16'h1); observe({15'h0, bus.INT});
    rd(7'h25, 8'hBE, "rd25");
    rd(7'h27, 8'h11, "rd27");
    expect_v("int-cleared", 16'h0); observe({15'h0, bus.INT});

    // sample coherency: pulse during a read of 0x20
    load_smpl(64'h1100_BEEF_0000_ABCD);
    expect_v("coh-old", 16'h00CD);
    spi_xfer({1'b1, 7'h20, 8'h00, 24'h0}, 16, 1'b1, 64'h1100_BEEF_5678_1234, rx);
    observe({8'h00, rx[7:0]});
    rd(7'h20, 8'h34, "coh-new");
    rd(7'h22, 8'h78, "rd22");

    // aborted write then full frames
    spi_xfer({1'b0, 7'h05, 8'h55, 24'h0}, 12, 1'b0, 64'h0, rx);
    rd(7'h05, 8'h00, "abort-unchanged");
    wr(7'h05, 8'hA5);
    rd(7'h05, 8'hA5, "rd05-after-abort");

    // dropped writes and unmapped reads
    wr(7'h22, 8'h99);
    rd(7'h22, 8'h78, "ro-write-dropped");
    rd(7'h30, 8'h00, "unmapped-read");

    // clearing INT enable forces INT low; later samples keep it low
    expect_v("int-before-disable", 16'h1); observe({15'h0, bus.INT});
    wr(7'h0D, 8'h00);
    expect_v("int-disabled", 16'h0); observe({15'h0, bus.INT});
    load_smpl(64'h1100_BEEF_5678_1234);
    expect_v("int-stays-low", 16'h0); observe({15'h0, bus.INT});
    expect_v("setup-sticky", 16'h1); observe({15'h0, setup_done});

    // 40-bit read of 0x20
`ifdef NEMO_BURST_EN
    expect_v("burst", 16'h3412);
    expect_v("burst-hi", 16'h7856);
`else
    expect_v("burst", 16'h3400);
    expect_v("burst-hi", 16'h0000);
`endif
    spi_xfer({1'b1, 7'h20, 8'h00, 24'h0}, 40, 1'b0, 64'h0, rx);
    observe(rx[31:16]);
    observe(rx[15:0]);

    end_stb = 1'b1;
    wclk(1);
    end_stb = 1'b0;
    wclk(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nemo_spi_slave.md
Name: nemo_spi_slave

Overview:
- SPI responder (slave) for the inertial-sensor link, modelling the sensor end of the bus that the inertial interface drives as master.
- Decodes 16-bit read/write frames into a config register file and a set of read-only sample registers.
- Samples are loaded from a parallel port. INT is raised when a new sample is ready.
- Used in sensor models, benches, and FPGA loopback builds.

Parameters:
- SCLK_SYNC_STAGES, 2, flops in the synchronizer chain for SS_n, SCLK and MOSI (minimum 2).
- INT_CFG_ADDR, 7'h0D, config address whose bit1 enables INT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- SS_n  input  1  SPI slave select, active low, asynchronous to clk
- SCLK  input  1  SPI clock, idles high (mode 3), asynchronous to clk
- MOSI  input  1  SPI data from master
- MISO  output  1  SPI data to master
- INT  output  1  data-ready interrupt, active high
- smpl_vld  input  1  one-clk strobe: smpl_data is a new sample set
- smpl_data  input  64  four 16-bit channels; ch0 in [15:0] … ch3 in [63:48]
- setup_done  output  1  high once INT_CFG_ADDR, 0x10 and 0x11 have each been written

Behaviour:
- Reset (rst_n low at posedge clk): all outputs 0, config regs 0, data regs 0, state IDLE, bit count 0. Reset mid-frame aborts the frame with no commit.
- Input handling:
  - SS_n, SCLK and MOSI pass through SCLK_SYNC_STAGES flops, plus one extra flop for edge detection.
  - Edge-to-action latency is SCLK_SYNC_STAGES+1 clk. SCLK must stay high and low for at least SCLK_SYNC_STAGES+2 clk each.
- Frame format, MSB first:
  - bit15: 1 = read, 0 = write.
  - bits14:8: address.
  - bits7:0: write data, or read data returned on MISO.
- Timing: MOSI is sampled on SCLK rise. MISO changes on SCLK fall.
- Registers:
  - 0x00–0x1F: R/W config, 8 bits each.
  - 0x20–0x27: read-only data. Channel n low byte is at 0x20+2n, high byte at 0x21+2n.
  - Writes to 0x20–0x7F are dropped. Reads of 0x28–0x7F return 0x00.
- FSM:
  - IDLE: SS_n fall → CMD, bit count cleared, MISO=0.
  - CMD: shift in 8 bits. On the 8th rise, latch R/W and address, and load the read byte into the MISO shift register. On the next SCLK fall MISO presents bit7 → DATA.
  - DATA: shift in 8 bits, shift MISO out on falls. On the 16th rise, a write commits in the same cycle the rise is detected → DONE.
  - DONE: further SCLK edges are ignored and MISO=0 (unless NEMO_BURST_EN).
  - Any state: SS_n rise → IDLE, MISO=0. A frame of fewer than 16 bits commits nothing.
- MISO is 0 whenever SS_n is high and throughout CMD. No tristate.
- Sample coherency:
  - smpl_vld with SS_n high: data regs load on the next clk.
  - smpl_vld with SS_n low: sample is held in a pending buffer and applied on the clk after SS_n rises.
  - A second smpl_vld while pending: newest value wins.
- INT:
  - Set on the data-reg load cycle when config[INT_CFG_ADDR][1]=1.
  - Cleared when SS_n rises after a completed read of 0x27.
  - Simultaneous set and clear: set wins.
  - Clearing config bit1 forces INT low on the commit cycle.
- setup_done: sticky, set on the commit cycle of the last of the three required writes (any order). Cleared only by reset.

Optional Feature:
- Macro NEMO_BURST_EN.
- Defined: after the 16th bit, each further 8 bits access address+1. Writes commit every 8th rise; reads reload MISO. Address wraps 0x7F→0x00. INT clears if 0x27 was read anywhere in the burst.
- Undefined: bits after the 16th are ignored and MISO=0 in DONE.

Test Plan:
- Reset with SS_n=1 → MISO=0, INT=0, setup_done=0. Then read 0x10 → MISO byte 0x00.
- Write 0x0D=0x02, 0x10=0x62, 0x11=0x0C → setup_done rises on commit of the third write; read-back of 0x10 gives 0x62.
- Config enabled, smpl_vld with ch0=16'hFF00 → INT=1. Read 0x20 returns 0x00, read 0x21 returns 0xFF; INT stays 1. Read 0x27 → INT=0 after SS_n rises.
- smpl_vld with ch0=16'h1234 pulsed mid-read of 0x20 (old value 16'hABCD) → frame returns 0xCD. The next read of 0x20 returns 0x34.
- SS_n raised after 12 bits of a write of 0x55 to 0x05 → 0x05 unchanged. The next full frame decodes correctly.
- NEMO_BURST_EN: read 0x20 for 40 SCLKs with ch0=16'h1234, ch1=16'h5678 → MISO bytes 0x34, 0x12, 0x78, 0x56. Without the macro, bytes 2–4 are 0x00.
